// File: rtl/pulse_emitter.sv
// pulse_emitter: turns event strobes into fixed-width, fixed-gap pulses on one wire,
// queueing events that arrive mid-pulse in a saturating pending counter.
module pulse_emitter #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_in,
  input  logic              clr_ovf,
  output logic              sig_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);
  localparam int CW = $clog2(HIGH_CYCLES > GAP_CYCLES ? HIGH_CYCLES : GAP_CYCLES);
  localparam logic [CW-1:0] H_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] G_LOAD = CW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
  state_t        state;
  logic [CW-1:0] count;
  logic          gap_end, push, pop, drop;
  // a trigger landing on the last gap cycle with nothing queued starts the next pulse directly
  always_comb begin
    gap_end = state == GAP && count == '0;
    pop     = gap_end && pending != '0;
    push    = trig_in && state != IDLE && !(gap_end && pending == '0);
    drop    = push && !pop && &pending;
  end
  assign busy = state != IDLE || pending != '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      sig_out  <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= push && !pop && !drop ? pending + 1'b1 : pop && !push ? pending - 1'b1 : pending;
      overflow <= drop || (overflow && !clr_ovf);
      case (state)
        IDLE: if (trig_in) begin
          state   <= HIGH;
          count   <= H_LOAD;
          sig_out <= 1'b1;
        end
        HIGH: if (count != '0) count <= count - 1'b1;
        else begin
          state   <= GAP;
          count   <= G_LOAD;
          sig_out <= 1'b0;
        end
        GAP: if (count != '0) count <= count - 1'b1;
        else if (pop || trig_in) begin
          state   <= HIGH;
          count   <= H_LOAD;
          sig_out <= 1'b1;
        end else state <= IDLE;
        default: begin
          state   <= IDLE;
          sig_out <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_emitter.sv
// tb_pulse_emitter: vector table, directed corner sequences and random traffic against a timeline model.
module tb_pulse_emitter;
  localparam int H = 4, G = 4, PW = 3, PMAX = 7;
  logic clk = 0, rst = 1, trig_in = 0, clr_ovf = 0;
  logic sig_out, busy, overflow;
  logic [PW-1:0] pending;
  pulse_emitter #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW)) dut (
    .clk(clk), .rst(rst), .trig_in(trig_in), .clr_ovf(clr_ovf),
    .sig_out(sig_out), .busy(busy), .pending(pending), .overflow(overflow)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  // model: a pulse is a time window [start, start+H) high then G low; queue is just a count
  int t = 0, m_start = -1, m_pend = 0, m_pulses = 0;
  bit m_ovf = 0;
  int rises = 0, highs = 0, det_cnt = 0;
  bit prev = 0;
  logic d0 = 0, d1 = 0, d2 = 0;
  always @(posedge clk) begin
    d0 <= sig_out;
    d1 <= d0;
    d2 <= d1;
    if (d1 && !d2) det_cnt <= det_cnt + 1;
  end
  typedef struct {bit tr; bit sig; int pend; bit busy;} vec_t;
  vec_t tbl[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d actual=%0d required=%0d", nm, t, act, exp);
    end
  endtask
  task automatic model_edge(input bit tr, input bit clr);
    bit drop = 0;
    if (m_start < 0) begin
      if (tr) begin m_start = t + 1; m_pulses++; end
    end else if (t == m_start + H + G - 1) begin
      if (m_pend > 0) begin
        if (!tr) m_pend--;
        m_start = t + 1;
        m_pulses++;
      end else if (tr) begin
        m_start = t + 1;
        m_pulses++;
      end else m_start = -1;
    end else if (tr) begin
      if (m_pend < PMAX) m_pend++;
      else drop = 1;
    end
    m_ovf = drop ? 1'b1 : clr ? 1'b0 : m_ovf;
    t++;
  endtask
  task automatic step(input bit tr, input bit clr);
    bit esig;
    trig_in = tr;
    clr_ovf = clr;
    @(posedge clk);
    model_edge(tr, clr);
    #1;
    esig = m_start >= 0 && t >= m_start && t < m_start + H;
    chk("model_sig", sig_out, esig);
    chk("model_pending", pending, m_pend);
    chk("model_busy", busy, m_start >= 0 || m_pend > 0);
    chk("model_overflow", overflow, m_ovf);
    if (sig_out && !prev) rises++;
    if (sig_out) highs++;
    prev = sig_out;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask
  initial begin
    int r0, p0, d_0, h0;
    for (int i = 0; i < 10; i++) tbl[i] = '{tr: (i == 0), sig: (i < H), pend: 0, busy: (i < H + G)};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sig", sig_out, 0);
    chk("reset_pending", pending, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overflow", overflow, 0);
    rst = 0;
    idle(3);
    // single event
    r0 = rises;
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].tr, 0);
      chk("vec_sig", sig_out, tbl[i].sig);
      chk("vec_pending", pending, tbl[i].pend);
      chk("vec_busy", busy, tbl[i].busy);
    end
    chk("single_pulses", rises - r0, 1);
    // burst of three
    r0 = rises;
    step(1, 0); chk("burst_p0", pending, 0);
    step(1, 0); chk("burst_p1", pending, 1);
    step(1, 0); chk("burst_p2", pending, 2);
    idle(40);
    chk("burst_pulses", rises - r0, 3);
    chk("burst_ovf", overflow, 0);
    // saturation: push/pop coincide on first gap end, then later triggers are dropped
    r0 = rises;
    for (int i = 0; i < 12; i++) step(1, 0);
    chk("sat_pending", pending, PMAX);
    chk("sat_ovf", overflow, 1);
    idle(5);
    step(0, 1);
    chk("sat_clr", overflow, 0);
    chk("sat_busy", busy, 1);
    idle(90);
    chk("sat_pulses", rises - r0, 9);
    // reset mid-pulse with pending=3
    for (int i = 0; i < 4; i++) step(1, 0);
    chk("rst_pre_pending", pending, 3);
    chk("rst_pre_sig", sig_out, 1);
    #2 rst = 1;
    #1;
    chk("rst_async_sig", sig_out, 0);
    chk("rst_async_pending", pending, 0);
    chk("rst_async_ovf", overflow, 0);
    chk("rst_async_busy", busy, 0);
    @(posedge clk);
    #2 rst = 0;
    m_start = -1; m_pend = 0; m_ovf = 0; prev = 0;
    h0 = highs; r0 = rises;
    step(1, 0);
    idle(10);
    chk("rst_after_high", highs - h0, H);
    chk("rst_after_pulses", rises - r0, 1);
    // loopback: 5 events, first two back-to-back
    idle(4);
    r0 = rises; p0 = m_pulses; d_0 = det_cnt;
    step(1, 0);
    step(1, 0);
    for (int i = 0; i < 3; i++) begin
      idle($urandom_range(0, 12));
      step(1, 0);
    end
    idle(70);
    chk("loop_pulses", rises - r0, 5);
    chk("loop_detector", det_cnt - d_0, 5);
    // random traffic
    r0 = rises; p0 = m_pulses; d_0 = det_cnt;
    for (int i = 0; i < 500; i++) step($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
    idle(100);
    chk("rand_pulses", rises - r0, m_pulses - p0);
    chk("rand_detector", det_cnt - d_0, m_pulses - p0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
